// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch stage: FSM state, IF/ID payload and defaults.
package fetch_pkg;

    localparam int IF_DATA_W  = 32;
    localparam int IF_ADDR_W  = 32;
    localparam int PC_INC_DEF = 1;

    typedef enum logic {
        S_REQ  = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    // Payload of both the IF/ID register and the skid entry
    typedef struct packed {
        logic [IF_DATA_W-1:0] instr;
        logic [IF_ADDR_W-1:0] npc;
    } if_id_t;

endpackage

// File: rtl/fetch_skid_reg.sv
// One-entry holding register for a fetch consumed while the IF/ID register is stalled.
module fetch_skid_reg
    import fetch_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   load_i,
    input  logic   clr_i,
    input  if_id_t d_i,
    output if_id_t q_o,
    output logic   full_o
);

    if_id_t entry_q;
    logic   full_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry_q <= '0;
            full_q  <= 1'b0;
        end else if (clr_i) begin
            full_q  <= 1'b0;
        end else if (load_i) begin
            entry_q <= d_i;
            full_q  <= 1'b1;
        end
    end

    assign q_o    = entry_q;
    assign full_o = full_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC-driven imem request, IF/ID register, stall skid and flush.
// Optional FETCH_PERF_EN adds saturating fetch/stall counters as extra output ports.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int DATA_W = IF_DATA_W,
    parameter int ADDR_W = IF_ADDR_W,
    parameter int PC_INC = PC_INC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_in,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_req,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              stall,
    input  logic              flush,
    output logic              pc_write,
    output logic [DATA_W-1:0] instr_out,
    output logic [ADDR_W-1:0] npc_out,
    output logic              valid_out
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       fetch_cnt,
    output logic [15:0]       stall_cnt
`endif
);

    state_t            state_q;
    logic              imem_req_q;
    if_id_t            ifid_q;
    logic              valid_q;
    if_id_t            skid_q;
    logic              skid_full;
    logic              skid_load;
    logic              skid_clr;
    logic              accept;
    logic [ADDR_W-1:0] npc_d;
    if_id_t            fetch_d;

    assign npc_d   = pc_in + ADDR_W'(PC_INC);
    assign fetch_d = '{instr: imem_rdata, npc: npc_d};

    // A fetch is consumed whenever memory answers in S_REQ and no flush overrides it
    assign accept    = (state_q == S_REQ) && imem_ack && !flush;
    assign pc_write  = !rst && (flush || accept);
    assign skid_load = accept && stall;
    assign skid_clr  = flush || ((state_q == S_HOLD) && !stall);

    fetch_skid_reg u_skid (
        .clk    (clk),
        .rst    (rst),
        .load_i (skid_load),
        .clr_i  (skid_clr),
        .d_i    (fetch_d),
        .q_o    (skid_q),
        .full_o (skid_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_REQ;
            imem_req_q <= 1'b1;
            ifid_q     <= '0;
            valid_q    <= 1'b0;
        end else if (flush) begin
            state_q    <= S_REQ;
            imem_req_q <= 1'b1;
            valid_q    <= 1'b0;
        end else begin
            case (state_q)
                S_REQ: begin
                    if (imem_ack && !stall) begin
                        ifid_q  <= fetch_d;
                        valid_q <= 1'b1;
                    end else if (imem_ack) begin
                        state_q    <= S_HOLD;
                        imem_req_q <= 1'b0;
                    end else if (!stall) begin
                        valid_q <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        ifid_q     <= skid_q;
                        valid_q    <= skid_full;
                        state_q    <= S_REQ;
                        imem_req_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= S_REQ;
                    imem_req_q <= 1'b1;
                end
            endcase
        end
    end

    assign imem_addr = pc_in;
    assign imem_req  = imem_req_q;
    assign instr_out = ifid_q.instr;
    assign npc_out   = ifid_q.npc;
    assign valid_out = valid_q;

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt_q;
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (accept && (fetch_cnt_q != '1))
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (stall && valid_q && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: vector table plus IF/ID scoreboard, then async-reset sequence.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_in;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        flush;
    logic        pc_write;
    logic [31:0] instr_out;
    logic [31:0] npc_out;
    logic        valid_out;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt;
    logic [15:0] stall_cnt;
`endif

    fetch_stage dut (
        .clk        (clk),
        .rst        (rst),
        .pc_in      (pc_in),
        .imem_addr  (imem_addr),
        .imem_req   (imem_req),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .stall      (stall),
        .flush      (flush),
        .pc_write   (pc_write),
        .instr_out  (instr_out),
        .npc_out    (npc_out),
        .valid_out  (valid_out)
`ifdef FETCH_PERF_EN
        ,
        .fetch_cnt  (fetch_cnt),
        .stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        flush;
        logic        ack;
        logic [31:0] pc;
        logic [31:0] rdata;
        logic        pw;
        logic        req;
        logic        push;
        logic        ld;
        logic        vld;
    } vec_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] npc;
    } exp_t;

    vec_t vq[$];
    exp_t sb[$];
    exp_t held;
    int   errors = 0;
    int   checks = 0;
    int   exp_fetch = 0;
    int   exp_stall = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic s, input logic f, input logic a,
                                input logic [31:0] pc, input logic [31:0] rd,
                                input logic pw, input logic req, input logic push,
                                input logic ld, input logic vld);
        vec_t v;
        v.stall = s; v.flush = f; v.ack = a; v.pc = pc; v.rdata = rd;
        v.pw = pw; v.req = req; v.push = push; v.ld = ld; v.vld = vld;
        return v;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //                 stall flush ack pc            rdata         pw req push ld vld
        vq.push_back(mk(0, 0, 1, 32'h10,       32'hA000_0000, 1, 1, 1, 1, 1));
        vq.push_back(mk(0, 0, 1, 32'h11,       32'hA000_0001, 1, 1, 1, 1, 1));
        vq.push_back(mk(0, 0, 1, 32'h12,       32'hA000_0002, 1, 1, 1, 1, 1));
        vq.push_back(mk(0, 0, 0, 32'h13,       32'h0BAD_0000, 0, 1, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 32'h13,       32'h0BAD_0001, 0, 1, 0, 0, 0));
        vq.push_back(mk(0, 0, 1, 32'h1F,       32'h1111_1111, 1, 1, 1, 1, 1));
        vq.push_back(mk(1, 0, 1, 32'h20,       32'hDEAD_BEEF, 1, 1, 1, 0, 1));
        vq.push_back(mk(1, 0, 0, 32'h21,       32'h0BAD_0002, 0, 0, 0, 0, 1));
        vq.push_back(mk(1, 0, 1, 32'h21,       32'h0BAD_0003, 0, 0, 0, 0, 1));
        vq.push_back(mk(0, 0, 0, 32'h21,       32'h0BAD_0004, 0, 0, 0, 1, 1));
        vq.push_back(mk(1, 0, 1, 32'h30,       32'h3333_3333, 1, 1, 1, 0, 1));
        vq.push_back(mk(1, 1, 1, 32'h31,       32'h0BAD_0005, 1, 0, 0, 0, 0));
        vq.push_back(mk(1, 0, 0, 32'h31,       32'h0BAD_0006, 0, 1, 0, 0, 0));
        vq.push_back(mk(0, 0, 1, 32'h31,       32'h4444_4444, 1, 1, 1, 1, 1));
        vq.push_back(mk(0, 1, 1, 32'h32,       32'h5555_5555, 1, 1, 0, 0, 0));
        vq.push_back(mk(0, 0, 1, 32'hFFFF_FFFF, 32'h6666_6666, 1, 1, 1, 1, 1));
        vq.push_back(mk(1, 0, 0, 32'h0,        32'h0BAD_0007, 0, 1, 0, 0, 1));

        rst = 1'b1; stall = 1'b0; flush = 1'b0; imem_ack = 1'b1;
        pc_in = 32'h55; imem_rdata = 32'hFFFF_0000;
        #1;
        chk("reset pc_write", {63'b0, pc_write}, 64'd0);
        chk("reset imem_req", {63'b0, imem_req}, 64'd1);
        chk("reset valid_out", {63'b0, valid_out}, 64'd0);
        chk("reset instr_out", {32'b0, instr_out}, 64'd0);
        chk("reset npc_out", {32'b0, npc_out}, 64'd0);
`ifdef FETCH_PERF_EN
        chk("reset fetch_cnt", {32'b0, fetch_cnt}, 64'd0);
        chk("reset stall_cnt", {48'b0, stall_cnt}, 64'd0);
`endif
        @(negedge clk);
        rst = 1'b0; imem_ack = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            vec_t v;
            logic [31:0] n;
            v = vq[i];
            @(negedge clk);
            stall = v.stall; flush = v.flush; imem_ack = v.ack;
            pc_in = v.pc; imem_rdata = v.rdata;
            #1;
            if (stall && valid_out) exp_stall++;
            if (v.pw && !v.flush) exp_fetch++;
            chk($sformatf("v%0d pc_write", i), {63'b0, pc_write}, {63'b0, v.pw});
            chk($sformatf("v%0d imem_req", i), {63'b0, imem_req}, {63'b0, v.req});
            chk($sformatf("v%0d imem_addr", i), {32'b0, imem_addr}, {32'b0, v.pc});
            n = v.pc + 32'd1;
            if (v.flush) sb.delete();
            else if (v.push) sb.push_back('{instr: v.rdata, npc: n});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d valid_out", i), {63'b0, valid_out}, {63'b0, v.vld});
            if (v.ld) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL v%0d scoreboard: got empty queue required one entry", i);
                end else begin
                    held = sb.pop_front();
                end
            end
            if (v.vld) begin
                chk($sformatf("v%0d instr_out", i), {32'b0, instr_out}, {32'b0, held.instr});
                chk($sformatf("v%0d npc_out", i), {32'b0, npc_out}, {32'b0, held.npc});
            end
`ifdef FETCH_PERF_EN
            if (i == 2) chk("fetch_cnt after 3 fetches", {32'b0, fetch_cnt}, 64'd3);
`endif
        end
`ifdef FETCH_PERF_EN
        chk("fetch_cnt final", {32'b0, fetch_cnt}, 64'(exp_fetch));
        chk("stall_cnt final", {48'b0, stall_cnt}, 64'(exp_stall));
`endif

        // Enter S_HOLD, then hit reset between clock edges
        @(negedge clk);
        stall = 1'b1; flush = 1'b0; imem_ack = 1'b1; pc_in = 32'h40; imem_rdata = 32'h7777_7777;
        @(posedge clk);
        #1;
        chk("pre-reset hold imem_req", {63'b0, imem_req}, 64'd0);
        chk("pre-reset hold valid_out", {63'b0, valid_out}, 64'd1);
        #2;
        imem_ack = 1'b0;
        rst = 1'b1;
        #1;
        chk("async reset valid_out", {63'b0, valid_out}, 64'd0);
        chk("async reset imem_req", {63'b0, imem_req}, 64'd1);
        chk("async reset pc_write", {63'b0, pc_write}, 64'd0);
        chk("async reset instr_out", {32'b0, instr_out}, 64'd0);
        @(negedge clk);
        rst = 1'b0; stall = 1'b0; imem_ack = 1'b1; pc_in = 32'h50; imem_rdata = 32'h8888_8888;
        #1;
        chk("post-reset pc_write", {63'b0, pc_write}, 64'd1);
        chk("post-reset imem_req", {63'b0, imem_req}, 64'd1);
        @(posedge clk);
        #1;
        chk("post-reset valid_out", {63'b0, valid_out}, 64'd1);
        chk("post-reset instr_out", {32'b0, instr_out}, 64'h8888_8888);
        chk("post-reset npc_out", {32'b0, npc_out}, 64'h51);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
